// File: rtl/prog_mem_loader_pkg.sv
// rtl/prog_mem_loader_pkg.sv - shared states and constants for the program memory loader
package prog_mem_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WR,
        S_CSUM,
        S_ERR
    } pml_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [3:0] MEM_WE_INSTR  = 4'b0011;

endpackage

// File: rtl/pml_timeout.sv
// rtl/pml_timeout.sv - idle-gap watchdog: reloads on clear or while disabled, expires after TIMEOUT_CYCLES idle clocks
module pml_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clear || !enable) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Zero means the watchdog is disabled; a byte arriving this cycle always wins.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (cnt == '0);

endmodule

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - frames a byte stream into 18-bit instructions for the program BRAM
// Optional trailing checksum byte when PML_CHECKSUM_EN is defined.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int         ADDR_W         = 10,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [17:0]       mem_wdata,
    output logic [3:0]        mem_we,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    pml_state_t        state;
    pml_state_t        state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       instr_cnt;
    logic [1:0]        b0;
    logic [7:0]        b1;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len_w;
    logic              accept;
    logic              is_sync;
    logic              last;
    logic              finish;
    logic              tmo_en;
    logic              tmo_expired;
`ifdef PML_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign in_ready = (state != S_WR);
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign len_w    = {len_hi, in_data};
    assign last     = (instr_cnt == 16'd1);
    assign tmo_en   = !(state inside {S_IDLE, S_ERR, S_WR});
    assign mem_we   = (state == S_WR) ? MEM_WE_INSTR : 4'b0000;
    assign mem_addr = addr;

    pml_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (tmo_en),
        .expired(tmo_expired)
    );

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            S_IDLE, S_ERR: if (accept && is_sync) state_nxt = S_LEN_HI;
            S_LEN_HI:      if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO:      if (accept) state_nxt = ((len_w == 16'd0) || ({1'b0, len_w} > DEPTH)) ? S_ERR : S_B0;
            S_B0:          if (accept) state_nxt = S_B1;
            S_B1:          if (accept) state_nxt = S_B2;
            S_B2:          if (accept) state_nxt = S_WR;
            S_WR: begin
                if (!last) begin
                    state_nxt = S_B0;
                end else begin
`ifdef PML_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_IDLE;
                    finish    = 1'b1;
`endif
                end
            end
            S_CSUM: begin
`ifdef PML_CHECKSUM_EN
                if (accept) begin
                    if (in_data == csum) begin
                        state_nxt = S_IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_expired) state_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi    <= '0;
            instr_cnt <= '0;
            b0        <= '0;
            b1        <= '0;
            addr      <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef PML_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (is_sync) begin
                            cpu_reset <= 1'b1;
                            load_err  <= 1'b0;
                            addr      <= '0;
                        end
                    end
                    S_LEN_HI: len_hi    <= in_data;
                    S_LEN_LO: instr_cnt <= len_w;
                    S_B0:     b0        <= in_data[1:0];
                    S_B1:     b1        <= in_data;
                    S_B2:     mem_wdata <= {b0, b1, in_data};
                    default:  ;
                endcase
`ifdef PML_CHECKSUM_EN
                if (state inside {S_IDLE, S_ERR})
                    csum <= '0;
                else if (state inside {S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2})
                    csum <= csum ^ in_data;
`endif
            end
            // Hold the address on the final write so a full-depth image never wraps to 0.
            if (state == S_WR) begin
                instr_cnt <= instr_cnt - 16'd1;
                if (!last) addr <= addr + 1'b1;
            end
            if (finish) begin
                load_done <= 1'b1;
                cpu_reset <= 1'b0;
            end
            if (state_nxt == S_ERR) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb/tb_prog_mem_loader.sv - table-driven bench for prog_mem_loader (ADDR_W=10, TIMEOUT_CYCLES=50)
module tb_prog_mem_loader;

    localparam int ADDR_W = 10;
    localparam int TO     = 50;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [17:0]       mem_wdata;
    logic [3:0]        mem_we;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    prog_mem_loader #(
        .ADDR_W        (ADDR_W),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .load_err (load_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [17:0]       data;
        logic [3:0]        we;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] len;
        logic [7:0]  d [6];
        int          nwr;
        logic [17:0] e0;
        logic [17:0] e1;
        bit          ok;
    } vec_t;

    wr_t  wrq[$];
    int   done_cnt = 0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs [5];

    always @(negedge clk) begin
        if (mem_we != 4'b0000) wrq.push_back('{mem_addr, mem_wdata, mem_we});
        if (load_done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] len, input int nwr, input logic [7:0] d [6]);
`ifdef PML_CHECKSUM_EN
        logic [7:0] x;
        x = len[15:8] ^ len[7:0];
`endif
        send_byte(8'hA5);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        for (int i = 0; i < 3 * nwr; i++) begin
            send_byte(d[i]);
`ifdef PML_CHECKSUM_EN
            x = x ^ d[i];
`endif
        end
`ifdef PML_CHECKSUM_EN
        if (nwr > 0) send_byte(x);
`endif
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"basic",   16'd2,    '{8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD}, 2, 18'h31234, 18'h0ABCD, 1'b1};
        vecs[1] = '{"len0",    16'd0,    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 18'h0,     18'h0,     1'b0};
        vecs[2] = '{"len1025", 16'd1025, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 18'h0,     18'h0,     1'b0};
        vecs[3] = '{"b0hi",    16'd1,    '{8'hFD, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00}, 1, 18'h1FFFE, 18'h0,     1'b1};
        vecs[4] = '{"syncdat", 16'd1,    '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00}, 1, 18'h1A5A5, 18'h0,     1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'h0);
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_load_err", 32'(load_err), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            wrq.delete();
            done_cnt = 0;
            send_frame(vecs[k].len, vecs[k].nwr, vecs[k].d);
            settle();
            check({vecs[k].name, "_nwr"}, 32'(wrq.size()), 32'(vecs[k].nwr));
            for (int i = 0; i < wrq.size() && i < vecs[k].nwr; i++) begin
                check({vecs[k].name, "_addr"}, 32'(wrq[i].addr), 32'(i));
                check({vecs[k].name, "_data"}, 32'(wrq[i].data), 32'((i == 0) ? vecs[k].e0 : vecs[k].e1));
                check({vecs[k].name, "_we"}, 32'(wrq[i].we), 32'h3);
            end
            check({vecs[k].name, "_done"}, 32'(done_cnt), 32'(vecs[k].ok));
            check({vecs[k].name, "_err"}, 32'(load_err), 32'(!vecs[k].ok));
            check({vecs[k].name, "_cpu_reset"}, 32'(cpu_reset), 32'(!vecs[k].ok));
        end

        // garbage before a frame is dropped
        wrq.delete();
        done_cnt = 0;
        send_byte(8'h00);
        send_byte(8'h55);
        check("garbage_cpu_reset", 32'(cpu_reset), 32'h0);
        send_frame(vecs[0].len, vecs[0].nwr, vecs[0].d);
        settle();
        check("garbage_nwr", 32'(wrq.size()), 32'd2);
        if (wrq.size() == 2) check("garbage_data1", 32'(wrq[1].data), 32'h0ABCD);
        check("garbage_done", 32'(done_cnt), 32'd1);

        // idle gap after B1: still fine at 49 clocks, error by 51
        send_byte(8'hA5);
        check("tmo_cpu_reset_on_sync", 32'(cpu_reset), 32'h1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("tmo_not_yet", 32'(load_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_err", 32'(load_err), 32'h1);
        check("tmo_cpu_reset", 32'(cpu_reset), 32'h1);
        send_byte(8'hA5);
        check("tmo_sync_clears_err", 32'(load_err), 32'h0);
        wrq.delete();
        done_cnt = 0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h07);
`ifdef PML_CHECKSUM_EN
        send_byte(8'h06);
`endif
        settle();
        check("tmo_recover_done", 32'(done_cnt), 32'd1);

        // full-depth image: last write lands at DEPTH-1 without wrapping
        begin
`ifdef PML_CHECKSUM_EN
            logic [7:0] x;
            x = 8'h04;
`endif
            wrq.delete();
            done_cnt = 0;
            send_byte(8'hA5);
            send_byte(8'h04);
            send_byte(8'h00);
            for (int i = 0; i < 1024; i++) begin
                send_byte(8'h00);
                send_byte(8'(i >> 8));
                send_byte(8'(i));
`ifdef PML_CHECKSUM_EN
                x = x ^ 8'(i >> 8) ^ 8'(i);
`endif
            end
`ifdef PML_CHECKSUM_EN
            send_byte(x);
`endif
            settle();
            check("full_nwr", 32'(wrq.size()), 32'd1024);
            if (wrq.size() == 1024) begin
                check("full_last_addr", 32'(wrq[1023].addr), 32'd1023);
                check("full_last_data", 32'(wrq[1023].data), 32'h003FF);
            end
            check("full_addr_hold", 32'(mem_addr), 32'd1023);
            check("full_done", 32'(done_cnt), 32'd1);
        end

`ifdef PML_CHECKSUM_EN
        done_cnt = 0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h01);
        settle();
        check("csum_good_done", 32'(done_cnt), 32'd1);
        check("csum_good_err", 32'(load_err), 32'h0);
        done_cnt = 0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
        settle();
        check("csum_bad_done", 32'(done_cnt), 32'd0);
        check("csum_bad_err", 32'(load_err), 32'h1);
        check("csum_bad_cpu_reset", 32'(cpu_reset), 32'h1);
`endif

        // reset asserted after the third instruction of a five-instruction frame
        wrq.delete();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h05);
        for (int i = 0; i < 9; i++) send_byte(8'(i + 1));
        repeat (2) @(posedge clk);
        #1;
        check("midrst_nwr", 32'(wrq.size()), 32'd3);
        rst_n = 1'b0;
        #2;
        check("midrst_addr", 32'(mem_addr), 32'h0);
        check("midrst_wdata", 32'(mem_wdata), 32'h0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        wrq.delete();
        done_cnt = 0;
        send_frame(vecs[0].len, vecs[0].nwr, vecs[0].d);
        settle();
        check("postrst_nwr", 32'(wrq.size()), 32'd2);
        if (wrq.size() == 2) begin
            check("postrst_addr0", 32'(wrq[0].addr), 32'h0);
            check("postrst_data0", 32'(wrq[0].data), 32'h31234);
        end
        check("postrst_done", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
